video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Parametrised VGA/DVI raster timing generator; next generation of the fixed-polarity hvsync block.
//  Adds: pixel clock-enable, per-axis sync polarity, zero-skew registered sync/DE, frame/line pulses,
//  and a PIPE_DLY-stage delayed copy of hsync/vsync/DE to match downstream BRAM/pixel pipeline latency.
//  Sits between the clock tree and pixel source (e.g. BRAM framebuffer reader) and the video PHY.
// PARAMETERS
//  H_DISPLAY   640  visible pixels per line
//  H_FRONT     16   horizontal front porch (pixels)
//  H_SYNC      96   horizontal sync width (pixels)
//  H_BACK      48   horizontal back porch (pixels)
//  V_DISPLAY   480  visible lines per frame
//  V_FRONT     10   vertical front porch (lines)
//  V_SYNC      2    vertical sync width (lines)
//  V_BACK      33   vertical back porch (lines)
//  H_SYNC_POL  0    hsync active level (0 = active-low, 1 = active-high)
//  V_SYNC_POL  0    vsync active level (0 = active-low, 1 = active-high)
//  POS_W       11   width of hpos/vpos; H_TOTAL-1 and V_TOTAL-1 must fit
//  PIPE_DLY    0    delay, in pix_ce strobes, of *_d outputs (0..15; 0 = *_d equal undelayed)
// PORTS
//  clk          in   1      pixel-domain clock
//  reset        in   1      synchronous, active-high reset
//  pix_ce       in   1      pixel clock enable; all timing state advances only when 1
//  hpos         out  POS_W  current column, 0..H_TOTAL-1
//  vpos         out  POS_W  current line, 0..V_TOTAL-1
//  display_on   out  1      1 when hpos<H_DISPLAY and vpos<V_DISPLAY
//  hsync        out  1      horizontal sync, polarity per H_SYNC_POL
//  vsync        out  1      vertical sync, polarity per V_SYNC_POL
//  line_start   out  1      1-clk pulse in the cycle hpos becomes 0
//  frame_start  out  1      1-clk pulse in the cycle (hpos,vpos) becomes (0,0)
//  hsync_d      out  1      hsync delayed PIPE_DLY pix_ce strobes
//  vsync_d      out  1      vsync delayed PIPE_DLY pix_ce strobes
//  de_d         out  1      display_on delayed PIPE_DLY pix_ce strobes
// BEHAVIOUR
//  H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Hsync region: H_DISPLAY+H_FRONT ..
//   H_DISPLAY+H_FRONT+H_SYNC-1 inclusive; vsync region same form on vpos.
//  Reset (sync, wins over pix_ce): hpos=H_TOTAL-1, vpos=V_TOTAL-1, display_on=0, hsync=~H_SYNC_POL,
//   vsync=~V_SYNC_POL, line_start=0, frame_start=0, delay pipe filled with inactive syncs and de=0.
//   Reset mid-frame takes effect at the next clk edge regardless of position.
//  Each clk with pix_ce=1: hpos<=hpos+1, or 0 at H_TOTAL-1; when hpos wraps, vpos<=vpos+1, or 0 at
//   V_TOTAL-1. Both counters wrap on the same edge at end of frame.
//  display_on/hsync/vsync are registered, decoded from the next counter values, so they are
//   cycle-aligned with hpos/vpos (zero skew, no decode lag). All outputs are registered.
//  First pix_ce after reset moves to (0,0): display_on=1, line_start=1, frame_start=1 that cycle.
//  pix_ce=0: counters, sync, DE and delay pipe hold; line_start/frame_start forced 0 (never >1 clk).
//  Delay pipe: PIPE_DLY-deep shift register of {hsync,vsync,display_on}, shifts on pix_ce only.
//   PIPE_DLY=0: *_d are wires equal to hsync/vsync/display_on.
//  Counter arithmetic is POS_W-bit unsigned; no intermediate wider than POS_W; no overflow possible.
// TESTING
//  1 reset held 3 clks -> hpos=799, vpos=524, hsync=vsync=1, display_on=0, pulses 0, *_d inactive.
//  2 pix_ce=1 after reset -> clk1 (0,0) frame_start=line_start=1; each line 800 clks; hsync=0 exactly
//    hpos 656..751; display_on=0 at hpos 640; vsync=0 exactly vpos 490..491; frame = 420000 clks.
//  3 pix_ce=1 every 2nd clk -> line = 1600 clks; outputs hold on idle clks; line_start high 1 clk/line.
//  4 PIPE_DLY=2 -> de_d/hsync_d/vsync_d equal display_on/hsync/vsync of 2 pix_ce strobes earlier,
//    also with irregular pix_ce pattern.
//  5 H_SYNC_POL=1,V_SYNC_POL=1, small timing (H 8/2/3/1, V 4/1/2/1) -> syncs high only in region;
//    H_TOTAL=14, V_TOTAL=8 wrap exactly.
//  6 reset asserted at (300,200) with display_on=1 -> next clk all outputs equal reset values.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with pixel clock enable,
// per-axis sync polarity, zero-skew registered sync/DE and a delayed sync/DE copy.
module video_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int POS_W      = 11,
   parameter int PIPE_DLY   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             display_on,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start,
   output logic             hsync_d,
   output logic             vsync_d,
   output logic             de_d
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] H_DE   = POS_W'(H_DISPLAY);
   localparam logic [POS_W-1:0] V_DE   = POS_W'(V_DISPLAY);
   localparam logic [POS_W-1:0] H_SS   = POS_W'(H_DISPLAY + H_FRONT);
   localparam logic [POS_W-1:0] H_SE   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [POS_W-1:0] V_SS   = POS_W'(V_DISPLAY + V_FRONT);
   localparam logic [POS_W-1:0] V_SE   = POS_W'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [POS_W-1:0] w_hn, w_vn;
   logic             w_de_n, w_hs_n, w_vs_n;

   // Syncs and DE are decoded from the next counter values so they land with the counters.
   always_comb begin
      w_hn   = (hpos == H_LAST) ? '0 : hpos + POS_W'(1);
      w_vn   = (hpos != H_LAST) ? vpos : (vpos == V_LAST) ? '0 : vpos + POS_W'(1);
      w_de_n = (w_hn < H_DE) && (w_vn < V_DE);
      w_hs_n = (w_hn >= H_SS && w_hn < H_SE) ? H_SYNC_POL : ~H_SYNC_POL;
      w_vs_n = (w_vn >= V_SS && w_vn < V_SE) ? V_SYNC_POL : ~V_SYNC_POL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hpos        <= H_LAST;
         vpos        <= V_LAST;
         display_on  <= 1'b0;
         hsync       <= ~H_SYNC_POL;
         vsync       <= ~V_SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_ce && (w_hn == '0);
         frame_start <= pix_ce && (w_hn == '0) && (w_vn == '0);
         if (pix_ce) begin
            hpos       <= w_hn;
            vpos       <= w_vn;
            display_on <= w_de_n;
            hsync      <= w_hs_n;
            vsync      <= w_vs_n;
         end
      end
   end

   generate
      if (PIPE_DLY == 0) begin : g_nodly
         assign {hsync_d, vsync_d, de_d} = {hsync, vsync, display_on};
      end else begin : g_dly
         logic [2:0] r_pipe [PIPE_DLY];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PIPE_DLY; i++) r_pipe[i] <= {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};
            end else if (pix_ce) begin
               r_pipe[0] <= {hsync, vsync, display_on};
               for (int i = 1; i < PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign {hsync_d, vsync_d, de_d} = r_pipe[PIPE_DLY-1];
      end
   endgenerate
endmodule
